// File: rtl/axil_rd_watchdog.sv
// AXI-lite read-path timeout guard: forwards one read at a time, answers SLVERR on timeout and drains the late slave response.
// Define AXIL_RD_WATCHDOG_STATS_EN to build the saturating timeout_count; otherwise it is tied to zero.
module axil_rd_watchdog #(
  parameter int          DATA_WIDTH        = 32,
  parameter int          ADDR_WIDTH        = 32,
  parameter int          FUNCTION_ID_WIDTH = 8,
  parameter int          TIMEOUT           = 1024,
  parameter logic [31:0] TIMEOUT_DATA      = 32'hDEADBEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        s_axil_araddr,
  input  logic [FUNCTION_ID_WIDTH-1:0] s_axil_aruser,
  input  logic [2:0]                   s_axil_arprot,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  output logic [DATA_WIDTH-1:0]        s_axil_rdata,
  output logic [1:0]                   s_axil_rresp,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready,
  output logic [ADDR_WIDTH-1:0]        m_axil_araddr,
  output logic [FUNCTION_ID_WIDTH-1:0] m_axil_aruser,
  output logic [2:0]                   m_axil_arprot,
  output logic                         m_axil_arvalid,
  input  logic                         m_axil_arready,
  input  logic [DATA_WIDTH-1:0]        m_axil_rdata,
  input  logic [1:0]                   m_axil_rresp,
  input  logic                         m_axil_rvalid,
  output logic                         m_axil_rready,
  output logic                         timeout_event,
  output logic [FUNCTION_ID_WIDTH-1:0] timeout_fid,
  output logic [31:0]                  timeout_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_WAIT_R = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  localparam int                    CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam int                    FILL_W    = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
  localparam logic [FILL_W-1:0]     FILL_EXT  = FILL_W'(TIMEOUT_DATA);
  localparam logic [DATA_WIDTH-1:0] FILL_DATA = FILL_EXT[DATA_WIDTH-1:0];
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  logic [2:0]                   state;
  logic                         ar_pend;
  logic                         r_pend;
  logic [CNT_W-1:0]             cnt;
  logic [ADDR_WIDTH-1:0]        araddr_q;
  logic [FUNCTION_ID_WIDTH-1:0] aruser_q;
  logic [2:0]                   arprot_q;
  logic [DATA_WIDTH-1:0]        rdata_q;
  logic [1:0]                   rresp_q;
  logic                         tmo_event_q;
  logic [FUNCTION_ID_WIDTH-1:0] tmo_fid_q;

  logic s_ar_hs, m_ar_hs, m_r_hs, r_done, tmo_fire, ar_pend_nxt, r_pend_nxt, timing;

  // The flags alone drive the downstream handshakes, so the background drain
  // after a timeout follows the same rules as the normal path.
  assign m_axil_arvalid = ar_pend;
  assign m_axil_rready  = r_pend & ~ar_pend;
  assign s_axil_arready = (state == ST_IDLE);
  assign s_axil_rvalid  = (state == ST_RESP);

  assign s_ar_hs     = s_axil_arvalid & s_axil_arready;
  assign m_ar_hs     = ar_pend & m_axil_arready;
  assign m_r_hs      = m_axil_rready & m_axil_rvalid;
  assign timing      = (state == ST_ADDR) | (state == ST_WAIT_R);
  assign r_done      = (state == ST_WAIT_R) & m_r_hs;
  assign tmo_fire    = timing & (cnt == CNT_LAST) & ~r_done;
  assign ar_pend_nxt = ar_pend & ~m_ar_hs;
  assign r_pend_nxt  = r_pend & ~m_r_hs;

  assign m_axil_araddr = araddr_q;
  assign m_axil_aruser = aruser_q;
  assign m_axil_arprot = arprot_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign timeout_event = tmo_event_q;
  assign timeout_fid   = tmo_fid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ar_pend     <= 1'b0;
      r_pend      <= 1'b0;
      cnt         <= '0;
      araddr_q    <= '0;
      aruser_q    <= '0;
      arprot_q    <= '0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      tmo_event_q <= 1'b0;
      tmo_fid_q   <= '0;
    end else begin
      tmo_event_q <= tmo_fire;
      ar_pend     <= s_ar_hs | ar_pend_nxt;
      r_pend      <= s_ar_hs | r_pend_nxt;
      case (state)
        ST_IDLE: begin
          if (s_ar_hs) begin
            araddr_q <= s_axil_araddr;
            aruser_q <= s_axil_aruser;
            arprot_q <= s_axil_arprot;
            cnt      <= '0;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR, ST_WAIT_R: begin
          cnt <= cnt + CNT_ONE;
          // A real response in the last counted cycle beats the timeout.
          if (r_done) begin
            rdata_q <= m_axil_rdata;
            rresp_q <= m_axil_rresp;
            state   <= ST_RESP;
          end else if (tmo_fire) begin
            rdata_q   <= FILL_DATA;
            rresp_q   <= RESP_SLVERR;
            tmo_fid_q <= aruser_q;
            state     <= ST_RESP;
          end else if (m_ar_hs) begin
            state <= ST_WAIT_R;
          end
        end
        ST_RESP: begin
          if (s_axil_rready) begin
            state <= (ar_pend_nxt | r_pend_nxt) ? ST_DRAIN : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!ar_pend_nxt && !r_pend_nxt) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXIL_RD_WATCHDOG_STATS_EN
  logic [31:0] tmo_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (tmo_fire) begin
      tmo_cnt_q <= sat_inc(tmo_cnt_q);
    end
  end

  assign timeout_count = tmo_cnt_q;
`else
  assign timeout_count = 32'd0;
`endif

endmodule

// File: tb/tb_axil_rd_watchdog.sv
// Bench for axil_rd_watchdog: directed and randomized reads against a cycle-timing reference model.
module tb_axil_rd_watchdog;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axil_araddr;
  logic [7:0]  s_axil_aruser;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  logic [31:0] m_axil_araddr;
  logic [7:0]  m_axil_aruser;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid;
  logic        m_axil_arready;
  logic [31:0] m_axil_rdata;
  logic [1:0]  m_axil_rresp;
  logic        m_axil_rvalid;
  logic        m_axil_rready;
  logic        timeout_event;
  logic [7:0]  timeout_fid;
  logic [31:0] timeout_count;

  axil_rd_watchdog #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .FUNCTION_ID_WIDTH(8),
    .TIMEOUT(TMO), .TIMEOUT_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_araddr(s_axil_araddr), .s_axil_aruser(s_axil_aruser), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_axil_araddr(m_axil_araddr), .m_axil_aruser(m_axil_aruser), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .timeout_event(timeout_event), .timeout_fid(timeout_fid), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  logic [7:0] exp_fid = 8'h00;

  // Observations of the last transaction, indexed by cycles after the upstream AR handshake.
  int o_acq, o_v, o_ev_cnt, o_ev_cyc, o_idle, o_arv_first, o_arv_last;
  int o_rv_cycles, o_unstable, o_fchg, o_mr_cyc, o_rhs;
  logic [31:0] o_data, o_addr;
  logic [1:0]  o_resp;
  logic [7:0]  o_user;
  logic [2:0]  o_prot;

  // Reference model: the response is real when the slave R beat lands no later
  // than cycle TMO; otherwise SLVERR appears at cycle TMO+1. The block is idle
  // again one cycle after both the upstream R handshake and the slave R beat.
  task automatic predict(input int ar_dly, input int r_dly, input int rr_dly,
                         output bit to, output int v, output int idle, output int r_cyc);
    int a_cyc, u_cyc;
    a_cyc = 1 + ar_dly;
    r_cyc = (r_dly < 0) ? -1 : a_cyc + 1 + r_dly;
    to    = (r_cyc < 0) || (r_cyc > TMO);
    v     = to ? TMO + 1 : r_cyc + 1;
    u_cyc = v + rr_dly;
    idle  = (r_cyc < 0) ? -1 : ((u_cyc > r_cyc) ? u_cyc : r_cyc) + 1;
  endtask

  function automatic int exp_count();
`ifdef AXIL_RD_WATCHDOG_STATS_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic idle_inputs();
    s_axil_arvalid = 1'b0;
    s_axil_araddr  = '0;
    s_axil_aruser  = '0;
    s_axil_arprot  = '0;
    s_axil_rready  = 1'b0;
    m_axil_arready = 1'b0;
    m_axil_rvalid  = 1'b0;
    m_axil_rdata   = '0;
    m_axil_rresp   = '0;
  endtask

  // Plays upstream master and downstream slave for one read; records what it sees.
  task automatic run_read(input logic [31:0] addr, input logic [7:0] fid, input logic [2:0] prot,
                          input int ar_dly, input int r_dly, input logic [31:0] data,
                          input logic [1:0] resp, input int rr_dly, input int stop_at);
    int a_cyc, r_cyc, c, guard;
    bit r_done, finished;
    a_cyc = 1 + ar_dly;
    r_cyc = (r_dly < 0) ? -1 : a_cyc + 1 + r_dly;
    o_v = -1; o_ev_cnt = 0; o_ev_cyc = -1; o_idle = -1; o_arv_first = -1; o_arv_last = -1;
    o_rv_cycles = 0; o_unstable = 0; o_fchg = 0; o_mr_cyc = -1; o_rhs = 0;
    o_data = '0; o_resp = '0; o_addr = '0; o_user = '0; o_prot = '0;
    @(negedge clk);
    s_axil_araddr  = addr;
    s_axil_aruser  = fid;
    s_axil_arprot  = prot;
    s_axil_arvalid = 1'b1;
    guard = 0;
    while (!s_axil_arready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    o_acq = (guard < 200) ? 1 : 0;
    c = 0; r_done = 0; finished = (o_acq == 0);
    while (!finished) begin
      if (c >= 1 && m_axil_arvalid) begin
        if (o_arv_first < 0) begin
          o_arv_first = c; o_addr = m_axil_araddr; o_user = m_axil_aruser; o_prot = m_axil_arprot;
        end else if (m_axil_araddr !== o_addr || m_axil_aruser !== o_user || m_axil_arprot !== o_prot) begin
          o_fchg++;
        end
        o_arv_last = c;
      end
      if (s_axil_rvalid) begin
        if (o_v < 0) begin
          o_v = c; o_data = s_axil_rdata; o_resp = s_axil_rresp;
        end else if (s_axil_rdata !== o_data || s_axil_rresp !== o_resp) begin
          o_unstable++;
        end
        o_rv_cycles++;
      end
      if (timeout_event) begin
        o_ev_cnt++; o_ev_cyc = c;
      end
      if (c >= 1 && s_axil_arready && o_idle < 0) o_idle = c;
      s_axil_arvalid = (c == 0);
      m_axil_arready = (c == a_cyc);
      m_axil_rvalid  = (r_cyc >= 0 && c >= r_cyc && !r_done);
      m_axil_rdata   = m_axil_rvalid ? data : '0;
      m_axil_rresp   = m_axil_rvalid ? resp : '0;
      if (m_axil_rvalid && m_axil_rready) begin
        r_done = 1; o_mr_cyc = c;
      end
      s_axil_rready = (o_v >= 0 && c >= o_v + rr_dly);
      if (s_axil_rvalid && s_axil_rready) o_rhs++;
      if (stop_at > 0) finished = (c >= stop_at);
      else finished = (o_idle >= 0 && (r_cyc < 0 || r_done)) || (c >= 300);
      c++;
      if (!finished) @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (s_axil_arready !== 1'b1 || s_axil_rvalid !== 1'b0 || m_axil_arvalid !== 1'b0 ||
        m_axil_rready !== 1'b0 || timeout_event !== 1'b0) begin
      bad++;
      $display("FAIL %s handshake outputs: arready=%b rvalid=%b m_arvalid=%b m_rready=%b event=%b, want 1 0 0 0 0",
               tag, s_axil_arready, s_axil_rvalid, m_axil_arvalid, m_axil_rready, timeout_event);
    end
    total++;
    if (s_axil_rdata !== 32'd0 || s_axil_rresp !== 2'd0 || m_axil_araddr !== 32'd0 ||
        m_axil_aruser !== 8'd0 || m_axil_arprot !== 3'd0 || timeout_fid !== 8'd0 || timeout_count !== 32'd0) begin
      bad++;
      $display("FAIL %s data outputs: rdata=%h rresp=%0d araddr=%h aruser=%h arprot=%0d fid=%h count=%0d, want all 0",
               tag, s_axil_rdata, s_axil_rresp, m_axil_araddr, m_axil_aruser, m_axil_arprot, timeout_fid, timeout_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic test_normal();
    bit to; int v, idle, r_cyc;
    predict(0, 2, 0, to, v, idle, r_cyc);
    run_read(32'h40, 8'h03, 3'd0, 0, 2, 32'h12345678, 2'b00, 0, 0);
    total++;
    if (o_v !== v) begin bad++; $display("FAIL normal latency: got %0d want %0d", o_v, v); end
    total++;
    if (o_data !== 32'h12345678 || o_resp !== 2'b00) begin
      bad++; $display("FAIL normal data: got %h/%0d want 12345678/0", o_data, o_resp);
    end
    total++;
    if (o_ev_cnt !== 0) begin bad++; $display("FAIL normal event: got %0d pulses want 0", o_ev_cnt); end
    total++;
    if (o_arv_first !== 1 || o_addr !== 32'h40 || o_user !== 8'h03) begin
      bad++; $display("FAIL normal m_ar: first=%0d addr=%h user=%h want 1/40/03", o_arv_first, o_addr, o_user);
    end
    total++;
    if (o_idle !== idle) begin bad++; $display("FAIL normal idle: got %0d want %0d", o_idle, idle); end
  endtask

  task automatic test_timeout_drain();
    bit to; int v, idle, r_cyc;
    predict(0, 28, 0, to, v, idle, r_cyc);
    run_read(32'h44, 8'h03, 3'd2, 0, 28, 32'hAAAA5555, 2'b00, 0, 0);
    if (to) begin exp_cnt++; exp_fid = 8'h03; end
    total++;
    if (o_v !== v || v !== TMO + 1) begin bad++; $display("FAIL timeout latency: got %0d want %0d", o_v, TMO + 1); end
    total++;
    if (o_data !== 32'hDEADBEEF || o_resp !== 2'b10) begin
      bad++; $display("FAIL timeout data: got %h/%0d want deadbeef/2", o_data, o_resp);
    end
    total++;
    if (o_ev_cnt !== 1 || o_ev_cyc !== TMO + 1) begin
      bad++; $display("FAIL timeout event: got %0d pulses at %0d want 1 at %0d", o_ev_cnt, o_ev_cyc, TMO + 1);
    end
    total++;
    if (timeout_fid !== exp_fid) begin bad++; $display("FAIL timeout fid: got %h want %h", timeout_fid, exp_fid); end
    total++;
    if (o_rhs !== 1 || o_rv_cycles !== 1) begin
      bad++; $display("FAIL late data leak: got %0d handshakes %0d rvalid cycles want 1 1", o_rhs, o_rv_cycles);
    end
    total++;
    if (o_mr_cyc !== 30 || o_idle !== idle) begin
      bad++; $display("FAIL drain: slave R at %0d idle at %0d want 30/%0d", o_mr_cyc, o_idle, idle);
    end
    total++;
    if (timeout_count !== exp_count()) begin
      bad++; $display("FAIL timeout count: got %0d want %0d", timeout_count, exp_count());
    end
    run_read(32'h48, 8'h05, 3'd0, 1, 3, 32'h0000BEEF, 2'b00, 1, 0);
    total++;
    if (o_data !== 32'h0000BEEF || o_resp !== 2'b00 || o_ev_cnt !== 0) begin
      bad++; $display("FAIL after drain: got %h/%0d events %0d want 0000beef/0 0", o_data, o_resp, o_ev_cnt);
    end
  endtask

  task automatic test_ar_stall();
    bit to; int v, idle, r_cyc;
    predict(40, 2, 2, to, v, idle, r_cyc);
    run_read(32'h80, 8'h07, 3'd1, 40, 2, 32'h11112222, 2'b00, 2, 0);
    if (to) begin exp_cnt++; exp_fid = 8'h07; end
    total++;
    if (o_v !== v || o_resp !== 2'b10 || o_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL stall timeout: got cycle %0d %h/%0d want %0d deadbeef/2", o_v, o_data, o_resp, v);
    end
    total++;
    if (o_arv_first !== 1 || o_arv_last !== 41 || o_fchg !== 0) begin
      bad++; $display("FAIL stall arvalid: high %0d..%0d changes %0d want 1..41 0", o_arv_first, o_arv_last, o_fchg);
    end
    total++;
    if (o_mr_cyc !== r_cyc || o_idle !== idle) begin
      bad++; $display("FAIL stall drain: R at %0d idle at %0d want %0d/%0d", o_mr_cyc, o_idle, r_cyc, idle);
    end
  endtask

  task automatic test_boundary();
    bit to; int v, idle, r_cyc;
    predict(0, TMO - 2, 0, to, v, idle, r_cyc);
    run_read(32'hC0, 8'h09, 3'd0, 0, TMO - 2, 32'hCAFEF00D, 2'b01, 0, 0);
    total++;
    if (o_v !== v || o_data !== 32'hCAFEF00D || o_resp !== 2'b01 || o_ev_cnt !== 0) begin
      bad++; $display("FAIL boundary last-cycle R: cycle %0d %h/%0d events %0d want %0d cafef00d/1 0",
                      o_v, o_data, o_resp, o_ev_cnt, v);
    end
    predict(0, TMO - 1, 0, to, v, idle, r_cyc);
    run_read(32'hC4, 8'h0A, 3'd0, 0, TMO - 1, 32'h5A5A5A5A, 2'b00, 0, 0);
    if (to) begin exp_cnt++; exp_fid = 8'h0A; end
    total++;
    if (o_v !== v || o_resp !== 2'b10 || o_ev_cnt !== 1) begin
      bad++; $display("FAIL boundary one-late: cycle %0d resp %0d events %0d want %0d 2 1", o_v, o_resp, o_ev_cnt, v);
    end
    total++;
    if (o_idle !== idle || o_rhs !== 1) begin
      bad++; $display("FAIL boundary same-cycle drain: idle %0d hs %0d want %0d 1", o_idle, o_rhs, idle);
    end
  endtask

  task automatic test_never_answer();
    run_read(32'h100, 8'h03, 3'd0, 0, -1, 32'h0, 2'b00, 0, 25);
    total++;
    if (o_v !== TMO + 1 || o_data !== 32'hDEADBEEF || o_resp !== 2'b10 || o_ev_cnt !== 1) begin
      bad++; $display("FAIL dead slave: cycle %0d %h/%0d events %0d want %0d deadbeef/2 1",
                      o_v, o_data, o_resp, o_ev_cnt, TMO + 1);
    end
    total++;
    if (o_idle !== -1 || s_axil_arready !== 1'b0) begin
      bad++; $display("FAIL dead slave drain: idle at %0d arready %b want none 0", o_idle, s_axil_arready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0; exp_fid = 8'h00;
  endtask

  task automatic test_reset_mid();
    run_read(32'h200, 8'h0C, 3'd3, 0, -1, 32'h0, 2'b00, 0, 8);
    total++;
    if (m_axil_rready !== 1'b1) begin bad++; $display("FAIL mid wait_r: m_rready %b want 1", m_axil_rready); end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid reset");
    rst = 1'b0;
    exp_cnt = 0; exp_fid = 8'h00;
    run_read(32'h204, 8'h0D, 3'd0, 0, 1, 32'h76543210, 2'b00, 0, 0);
    total++;
    if (o_v !== 4 || o_data !== 32'h76543210 || o_resp !== 2'b00 || timeout_count !== 32'd0) begin
      bad++; $display("FAIL read after reset: cycle %0d %h/%0d count %0d want 4 76543210/0 0",
                      o_v, o_data, o_resp, timeout_count);
    end
  endtask

  task automatic test_back_to_back();
    bit to; int v, idle, r_cyc, ar_dly, r_dly, rr_dly;
    logic [31:0] addr, data, want;
    logic [7:0] fid;
    logic [2:0] prot;
    logic [1:0] resp;
    for (int n = 0; n < 40; n++) begin
      ar_dly = $urandom_range(0, 20);
      r_dly  = $urandom_range(0, 24);
      rr_dly = $urandom_range(0, 3);
      addr = $urandom; data = $urandom; fid = 8'($urandom); prot = 3'($urandom); resp = 2'($urandom);
      predict(ar_dly, r_dly, rr_dly, to, v, idle, r_cyc);
      run_read(addr, fid, prot, ar_dly, r_dly, data, resp, rr_dly, 0);
      if (to) begin exp_cnt++; exp_fid = fid; end
      want = to ? 32'hDEADBEEF : data;
      total++;
      if (o_v !== v || o_data !== want || o_resp !== (to ? 2'b10 : resp)) begin
        bad++; $display("FAIL rand[%0d] resp (ar=%0d r=%0d): cycle %0d %h/%0d want %0d %h/%0d",
                        n, ar_dly, r_dly, o_v, o_data, o_resp, v, want, to ? 2'b10 : resp);
      end
      total++;
      if (o_ev_cnt !== (to ? 1 : 0) || timeout_fid !== exp_fid) begin
        bad++; $display("FAIL rand[%0d] event: %0d pulses fid %h want %0d fid %h",
                        n, o_ev_cnt, timeout_fid, to ? 1 : 0, exp_fid);
      end
      total++;
      if (o_idle !== idle || o_mr_cyc !== r_cyc || o_rhs !== 1 || o_rv_cycles !== rr_dly + 1 || o_unstable !== 0) begin
        bad++; $display("FAIL rand[%0d] timing: idle %0d R %0d hs %0d rv %0d unst %0d want %0d %0d 1 %0d 0",
                        n, o_idle, o_mr_cyc, o_rhs, o_rv_cycles, o_unstable, idle, r_cyc, rr_dly + 1);
      end
      total++;
      if (o_arv_first !== 1 || o_arv_last !== 1 + ar_dly || o_addr !== addr || o_user !== fid ||
          o_prot !== prot || o_fchg !== 0) begin
        bad++; $display("FAIL rand[%0d] m_ar: %0d..%0d %h/%h/%0d chg %0d want 1..%0d %h/%h/%0d",
                        n, o_arv_first, o_arv_last, o_addr, o_user, o_prot, o_fchg, 1 + ar_dly, addr, fid, prot);
      end
      total++;
      if (timeout_count !== exp_count()) begin
        bad++; $display("FAIL rand[%0d] count: got %0d want %0d", n, timeout_count, exp_count());
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_normal();
    test_timeout_drain();
    test_ar_stall();
    test_boundary();
    test_never_answer();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
